// File: rtl/rate_pkg.sv
// Definitions shared by the interpolation and decimation rate stages:
// default ratio, counter-width helper and mode encodings.
package rate_pkg;

    localparam int RATE_M = 2000;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_SUM  = 1'b1
    } mode_t;

    // Bits needed to count 0..value-1; evaluated at elaboration only.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/r_dec_cnt.sv
// Modulo-M frame counter: advances on en, cleared synchronously by clr,
// and flags the sample that closes a frame.
module r_dec_cnt
    import rate_pkg::*;
#(
    parameter int M  = RATE_M,
    parameter int CW = clog2(M)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(M - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/r_dec.sv
// Decimating rate stage: one output per M valid inputs, either a picked
// sample at a programmable phase or the exact sum of the whole frame.
module r_dec
    import rate_pkg::*;
#(
    parameter  int Win  = 19,
    parameter  int M    = RATE_M,
    parameter  int CW   = clog2(M),
    localparam int Wout = Win + CW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [Win-1:0]  data_in,
    input  logic                   val_in,
    input  logic                   mode,
    input  logic        [CW-1:0]   phase,
    output logic signed [Wout-1:0] data_out,
    output logic                   val_out
);

    mode_t                  mode_q;
    logic                   mode_chg;
    logic        [CW-1:0]   cnt;
    logic                   wrap;
    logic signed [Wout-1:0] acc;
    logic signed [Wout-1:0] sample;
    logic signed [Wout-1:0] total;

    assign mode_chg = (mode_t'(mode) != mode_q);
    assign sample   = {{CW{data_in[Win-1]}}, data_in};
    // Wout = Win + CW bits holds M full-scale samples, so this add is exact.
    assign total    = acc + sample;

    // A mode change restarts the frame and swallows that cycle's sample.
    r_dec_cnt #(
        .M  (M),
        .CW (CW)
    ) u_cnt (
        .clk  (clk),
        .clr  (rst || mode_chg),
        .en   (val_in),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // NOTE: non-blocking assignments make every register here sample the
    // pre-edge acc/cnt, so the dump and the accumulator clear coexist safely.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            val_out  <= 1'b0;
            acc      <= '0;
            mode_q   <= mode_t'(mode);
        end else begin
            val_out <= 1'b0;
            if (mode_chg) begin
                mode_q <= mode_t'(mode);
                acc    <= '0;
            end else if (val_in) begin
                if (mode_q == MODE_PICK) begin
                    if (cnt == phase) begin
                        data_out <= sample;
                        val_out  <= 1'b1;
                    end
                end else if (wrap) begin
                    data_out <= total;
                    val_out  <= 1'b1;
                    acc      <= '0;
                end else begin
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_r_dec.sv
// Bench for r_dec: a small-ratio (M=4) and a default-ratio (M=2000) instance
// share one stimulus stream and are checked every cycle against a frame model.
module tb_r_dec;

    logic               clk;
    logic               rst;
    logic signed [18:0] data_in;
    logic               val_in;
    logic               mode;
    logic        [10:0] phase;

    logic signed [21:0] dout4;
    logic               val4;
    logic signed [29:0] dout2k;
    logic               val2k;

    int checks;
    int errors;

    // Model: samples collected in the current frame, per instance.
    longint fr    [2][2000];
    int     n     [2];
    logic   mq    [2];
    longint e_dat [2];
    logic   e_val [2];

    longint log4[$];
    longint log2k[$];

    r_dec #(.Win(19), .M(4), .CW(3)) u4 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .val_in   (val_in),
        .mode     (mode),
        .phase    (phase[2:0]),
        .data_out (dout4),
        .val_out  (val4)
    );

    r_dec u2k (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .val_in   (val_in),
        .mode     (mode),
        .phase    (phase),
        .data_out (dout2k),
        .val_out  (val2k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Outputs after this edge, derived from the frame rules.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int     m;
            int     ph;
            longint s;
            m  = (d == 0) ? 4 : 2000;
            ph = (d == 0) ? int'(phase[2:0]) : int'(phase);
            if (rst) begin
                n[d]     = 0;
                e_dat[d] = 0;
                e_val[d] = 1'b0;
                mq[d]    = mode;
            end else begin
                e_val[d] = 1'b0;
                if (mode != mq[d]) begin
                    mq[d] = mode;
                    n[d]  = 0;
                end else if (val_in) begin
                    fr[d][n[d]] = longint'(data_in);
                    if (!mq[d] && ph == n[d]) begin
                        e_dat[d] = longint'(data_in);
                        e_val[d] = 1'b1;
                    end
                    n[d] = n[d] + 1;
                    if (n[d] == m) begin
                        if (mq[d]) begin
                            s = 0;
                            for (int i = 0; i < m; i++) s = s + fr[d][i];
                            e_dat[d] = s;
                            e_val[d] = 1'b1;
                        end
                        n[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        check("u4_val", val4, e_val[0]);
        check("u4_data", dout4, e_dat[0]);
        check("u2k_val", val2k, e_val[1]);
        check("u2k_data", dout2k, e_dat[1]);
        if (val4 === 1'b1) log4.push_back(longint'(dout4));
        if (val2k === 1'b1) log2k.push_back(longint'(dout2k));
    endtask

    task automatic cyc(input logic r, input logic v, input int d, input logic md);
        rst     = r;
        val_in  = v;
        data_in = 19'(d);
        mode    = md;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic check_log(input string name, input int which, input longint req[$]);
        int sz;
        sz = (which == 0) ? log4.size() : log2k.size();
        check({name, "_pulses"}, sz, req.size());
        for (int i = 0; i < req.size() && i < sz; i++)
            check(name, (which == 0) ? log4[i] : log2k[i], req[i]);
        log4.delete();
        log2k.delete();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        val_in  = 1'b0;
        data_in = '0;
        mode    = 1'b0;
        phase   = 11'd2;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_data", dout4, 0);
        check("reset_val", val4, 0);
        log4.delete();
        log2k.delete();

        // Pick, phase 2, continuous input 10..21
        for (int k = 0; k < 12; k++) cyc(0, 1, 10 + k, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("pick_hold", dout4, 20);
        check_log("pick_out", 0, '{12, 16, 20});

        // Sum: mode-change cycle, then two frames and a clean third
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) cyc(0, 1, k, 1);
        for (int k = 0; k < 4; k++) cyc(0, 1, -5, 1);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 1);
        cyc(0, 0, 0, 1);
        check_log("sum_out", 0, '{10, -20, 4});

        // Gapped pick, phase 0: valid pattern 1,0,0,1,...
        phase = 11'd0;
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            cyc(0, 1, 100 + k, 0);
            if (k % 3 == 0) begin
                cyc(0, 0, -1, 0);
                cyc(0, 0, -1, 0);
            end
        end
        check_log("gap_out", 0, '{100, 104, 108});

        // phase=4 never matches; pick->sum switch at cnt=2 drops its sample
        phase = 11'd4;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 50 + k, 0);
        check("phase4_data", dout4, 0);
        cyc(0, 1, 99, 1);
        for (int k = 1; k <= 4; k++) cyc(0, 1, k, 1);
        check_log("switch_out", 0, '{10});

        // Reset mid-frame (cnt=3, acc=15)
        for (int k = 0; k < 3; k++) cyc(0, 1, 5, 1);
        cyc(1, 1, 7, 1);
        check("midrst_data", dout4, 0);
        check("midrst_val", val4, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 1);
        check_log("midrst_out", 0, '{4});

        // Full-scale negative frame at the default ratio
        cyc(1, 0, 0, 1);
        log4.delete();
        log2k.delete();
        for (int k = 0; k < 2000; k++) cyc(0, 1, -262144, 1);
        cyc(0, 0, 0, 1);
        check("sat_hold", dout2k, -524288000);
        check_log("sat_out", 1, '{-524288000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
